// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared widths and helpers for the FIR output path.
//               sat_round() gives a width-independent reference for the
//               round-then-saturate step (64-bit working precision).
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

  localparam int ACC_W_DEF      = 40;
  localparam int OUT_W_DEF      = 16;
  localparam int FRAC_SHIFT_DEF = 15;
  localparam int DEPTH_DEF      = 256;

  typedef struct packed {
    logic               sat;    // value had to be clamped
    logic signed [63:0] value;  // rounded, saturated sample
  } sat_round_t;

  // Round half-up by adding 2^(shift-1), then arithmetic shift, then clamp to
  // an out_w-bit signed range. Valid for accumulators narrower than 63 bits.
  function automatic sat_round_t sat_round(input logic signed [63:0] acc,
                                           input int shift,
                                           input int out_w);
    logic signed [63:0] half;
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_round_t         res;
    half = 64'sd1 <<< (shift - 1);
    r    = (acc + half) >>> shift;
    hi   = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo   = -hi - 64'sd1;
    res.sat   = (r > hi) || (r < lo);
    res.value = (r > hi) ? hi : ((r < lo) ? lo : r);
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_result_ram.sv
`default_nettype none
// ============================================================================
// Module      : fir_result_ram
// Description : Single-clock result buffer, one write port and one
//               registered read port. A read and write to the same address
//               in the same cycle returns the old contents. No reset.
// Ports       : clk                          - clock
//               i_we / i_waddr / i_wdata     - write port
//               i_re / i_raddr               - read request / address
//               o_rdata                      - read data, updated 1 cycle
//                                              after i_re, held otherwise
// Revision    : 1.0 - initial release
// ============================================================================
module fir_result_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Both statements sample r_mem before the update, giving read-before-write.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/fir_output_stage.sv
`default_nettype none
// ============================================================================
// Module      : fir_output_stage
// Description : Captures accumulator results on wr_en, rounds (half-up) and
//               saturates them to OUT_W bits over two pipeline stages, and
//               stores them at an auto-incrementing address. The host reads
//               the buffer back when busy is low.
// Ports       : clk, rst_n (async, active-low)
//               clr                      - start-of-run clear
//               wr_en, acc_in            - sample strobe / accumulator value
//               busy                     - filter running, blocks reads
//               rd_en, rd_addr           - host read request
//               rd_data, rd_valid, rd_err- host read response
//               count, full              - fill level
//               sat_flag, drop_err       - sticky status
// Revision    : 1.0 - initial release
// ============================================================================
module fir_output_stage
  import fir_pkg::*;
#(
  parameter int ACC_W      = ACC_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int FRAC_SHIFT = FRAC_SHIFT_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ACC_W-1:0]  acc_in,
  input  logic              busy,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [OUT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              sat_flag,
  output logic              drop_err
);

  // One guard bit on the rounding sum so adding the half-LSB never overflows.
  localparam int SUM_W = ACC_W + 1;

  localparam logic signed [SUM_W-1:0] c_half    = SUM_W'(1) << (FRAC_SHIFT - 1);
  localparam logic signed [SUM_W-1:0] c_sat_max = (SUM_W'(1) << (OUT_W - 1)) - SUM_W'(1);
  localparam logic signed [SUM_W-1:0] c_sat_min = ~c_sat_max;
  localparam logic [ADDR_W:0]         c_depth   = (ADDR_W + 1)'(DEPTH);

  // --------------------------------------------------------------------------
  // Stage 1: round
  // --------------------------------------------------------------------------
  logic signed [SUM_W-1:0] w_sum;
  logic signed [SUM_W-1:0] w_round;
  logic signed [SUM_W-1:0] r_s1_val;
  logic                    r_s1_valid;

  assign w_sum   = $signed({acc_in[ACC_W-1], acc_in}) + c_half;
  assign w_round = w_sum >>> FRAC_SHIFT;

  // --------------------------------------------------------------------------
  // Stage 2: saturate
  // --------------------------------------------------------------------------
  logic                    w_hi;
  logic                    w_lo;
  logic [OUT_W-1:0]        w_sat_val;
  logic [OUT_W-1:0]        r_s2_data;
  logic                    r_s2_valid;

  assign w_hi      = (r_s1_val > c_sat_max);
  assign w_lo      = (r_s1_val < c_sat_min);
  assign w_sat_val = w_hi ? c_sat_max[OUT_W-1:0] :
                     w_lo ? c_sat_min[OUT_W-1:0] : r_s1_val[OUT_W-1:0];

  // clr wins over a coincident wr_en and flushes anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_val   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else if (clr) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= wr_en;
      if (wr_en) begin
        r_s1_val <= w_round;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_sat_val;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Write pointer, fill level and sticky flags
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_sat_flag;
  logic              r_drop_err;
  logic              w_full;
  logic              w_mem_we;

  assign w_full   = (r_count == c_depth);
  // No wrap-around: once full, further samples are discarded.
  assign w_mem_we = r_s2_valid && !w_full && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_sat_flag <= 1'b0;
      r_drop_err <= 1'b0;
    end else if (clr) begin
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_sat_flag <= 1'b0;
      r_drop_err <= 1'b0;
    end else begin
      if (w_mem_we) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        r_count  <= r_count + (ADDR_W + 1)'(1);
      end
      if (r_s2_valid && w_full) begin
        r_drop_err <= 1'b1;
      end
      if (r_s1_valid && (w_hi || w_lo)) begin
        r_sat_flag <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Host read port
  // --------------------------------------------------------------------------
  logic             w_rd_ok;
  logic [OUT_W-1:0] w_ram_q;
  logic             r_rd_valid;
  logic             r_rd_err;
  logic             r_rd_seen;

  assign w_rd_ok = rd_en && !busy;

  // The RAM output register has no reset; r_rd_seen masks it to zero until
  // the first accepted read after reset reloads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_rd_seen  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_ok;
      r_rd_err   <= rd_en && busy;
      if (w_rd_ok) begin
        r_rd_seen <= 1'b1;
      end
    end
  end

  fir_result_ram #(
    .DATA_W (OUT_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (r_s2_data),
    .i_re    (w_rd_ok),
    .i_raddr (rd_addr),
    .o_rdata (w_ram_q)
  );

  assign rd_data  = r_rd_seen ? w_ram_q : '0;
  assign rd_valid = r_rd_valid;
  assign rd_err   = r_rd_err;
  assign count    = r_count;
  assign full     = w_full;
  assign sat_flag = r_sat_flag;
  assign drop_err = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_fir_output_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_output_stage
// Description : Self-checking bench for fir_output_stage. A default-size
//               instance runs directed and random sequences against an
//               arithmetic model of the buffer; a DEPTH=4 instance covers
//               the overrun behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_output_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default-size instance
  logic        clr, wr_en, busy, rd_en;
  logic [39:0] acc_in;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid, rd_err, full, sat_flag, drop_err;
  logic [8:0]  count;

  // DEPTH=4 instance
  logic        clr4, wr_en4, busy4, rd_en4;
  logic [39:0] acc_in4;
  logic [1:0]  rd_addr4;
  logic [15:0] rd_data4;
  logic        rd_valid4, rd_err4, full4, sat_flag4, drop_err4;
  logic [2:0]  count4;

  fir_output_stage dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .acc_in(acc_in),
    .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_err(rd_err), .count(count), .full(full),
    .sat_flag(sat_flag), .drop_err(drop_err)
  );

  fir_output_stage #(.DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr4), .wr_en(wr_en4), .acc_in(acc_in4),
    .busy(busy4), .rd_en(rd_en4), .rd_addr(rd_addr4), .rd_data(rd_data4),
    .rd_valid(rd_valid4), .rd_err(rd_err4), .count(count4), .full(full4),
    .sat_flag(sat_flag4), .drop_err(drop_err4)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the default instance
  logic [15:0] m_mem [256];
  int          m_count = 0;
  logic        m_sat   = 1'b0;
  logic [15:0] m_last_rd = 16'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Divide by 2^15 with floor after adding one half, then clamp to 16 bits.
  function automatic logic [16:0] ref_sample(input longint a);
    longint      n, q;
    logic        s;
    logic [15:0] v;
    n = a + 64'sd16384;
    q = n / 64'sd32768;
    if ((n % 64'sd32768) != 0 && n < 0) q = q - 1;
    if (q > 64'sd32767) begin
      s = 1'b1; v = 16'h7FFF;
    end else if (q < -64'sd32768) begin
      s = 1'b1; v = 16'h8000;
    end else begin
      s = 1'b0; v = q[15:0];
    end
    return {s, v};
  endfunction

  function automatic longint rand_acc();
    longint x;
    int     mode;
    mode = $urandom_range(0, 3);
    case (mode)
      0: x = longint'($urandom_range(0, 2097152)) - 64'sd1048576;
      1: x = (longint'($urandom_range(0, 80000)) - 64'sd40000) * 64'sd32768
             + 64'sd16384 + longint'($urandom_range(0, 2)) - 64'sd1;
      2: begin
        x = {$urandom, $urandom};
        x = (x <<< 24) >>> 24;
      end
      default: begin
        x = 64'sd32767 * 64'sd32768 + longint'($urandom_range(0, 65535));
        if ($urandom_range(0, 1) == 1) x = -x;
      end
    endcase
    return x;
  endfunction

  task automatic wr(input longint a);
    logic [16:0] r;
    r = ref_sample(a);
    wr_en  = 1'b1;
    acc_in = a[39:0];
    if (m_count < 256) begin
      m_mem[m_count] = r[15:0];
      m_count++;
    end
    if (r[16]) m_sat = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_count = 0;
    m_sat   = 1'b0;
  endtask

  task automatic rd(input int addr, input logic [15:0] exp, input string tag);
    busy    = 1'b0;
    rd_en   = 1'b1;
    rd_addr = addr[7:0];
    tick();
    rd_en = 1'b0;
    chk({tag, "_valid"}, rd_valid, 1'b1);
    chk({tag, "_data"}, rd_data, exp);
    m_last_rd = exp;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_data"}, rd_data, 16'h0);
    chk({tag, "_rd_valid"}, rd_valid, 1'b0);
    chk({tag, "_rd_err"}, rd_err, 1'b0);
    chk({tag, "_count"}, count, 9'd0);
    chk({tag, "_full"}, full, 1'b0);
    chk({tag, "_sat"}, sat_flag, 1'b0);
    chk({tag, "_drop"}, drop_err, 1'b0);
  endtask

  initial begin
    logic [15:0] t1_exp [5];
    longint      t1_acc [5];
    longint      a;
    t1_exp = '{16'd1, 16'd0, 16'd3, 16'd0, 16'hFFFF};
    t1_acc = '{64'sd16384, 64'sd16383, 64'sd98304, -64'sd16384, -64'sd16385};

    rst_n = 1'b0;
    clr = 1'b0; wr_en = 1'b0; busy = 1'b0; rd_en = 1'b0; acc_in = '0; rd_addr = '0;
    clr4 = 1'b0; wr_en4 = 1'b0; busy4 = 1'b0; rd_en4 = 1'b0; acc_in4 = '0; rd_addr4 = '0;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Overrun on the DEPTH=4 instance: samples 1..5
    for (int i = 1; i <= 5; i++) begin
      wr_en4  = 1'b1;
      acc_in4 = 40'(i * 32768);
      tick();
    end
    wr_en4 = 1'b0;
    chk("ovr_count3", count4, 3'd3);
    chk("ovr_notfull", full4, 1'b0);
    tick();
    chk("ovr_count4", count4, 3'd4);
    chk("ovr_full", full4, 1'b1);
    chk("ovr_nodrop_yet", drop_err4, 1'b0);
    tick();
    chk("ovr_drop", drop_err4, 1'b1);
    chk("ovr_count_hold", count4, 3'd4);
    for (int i = 0; i < 4; i++) begin
      rd_en4   = 1'b1;
      rd_addr4 = i[1:0];
      tick();
      rd_en4 = 1'b0;
      chk("ovr_rd_valid", rd_valid4, 1'b1);
      chk("ovr_rd_data", rd_data4, 16'(i + 1));
    end

    // Rounding
    do_clr();
    for (int i = 0; i < 5; i++) wr(t1_acc[i]);
    tick(); tick(); tick();
    chk("round_count", count, 9'd5);
    chk("round_sat", sat_flag, 1'b0);
    for (int i = 0; i < 5; i++) rd(i, t1_exp[i], "round_rd");

    // Saturation
    do_clr();
    wr(64'sd2147483648);
    wr(-64'sd2147483648);
    tick(); tick(); tick();
    chk("sat_count", count, 9'd2);
    chk("sat_flag_set", sat_flag, 1'b1);
    rd(0, 16'h7FFF, "sat_rd_pos");
    rd(1, 16'h8000, "sat_rd_neg");
    do_clr();
    chk("sat_flag_clr", sat_flag, 1'b0);
    chk("sat_count_clr", count, 9'd0);

    // Host read while busy is rejected
    busy  = 1'b1;
    rd_en = 1'b1;
    rd_addr = 8'd2;
    tick();
    rd_en = 1'b0;
    chk("busy_rd_err", rd_err, 1'b1);
    chk("busy_rd_valid", rd_valid, 1'b0);
    chk("busy_rd_hold", rd_data, m_last_rd);
    tick();
    chk("busy_rd_err_pulse", rd_err, 1'b0);
    rd(2, 16'd3, "idle_rd2");

    // Collision: final write lands in the first idle cycle
    busy   = 1'b1;
    wr_en  = 1'b1;
    acc_in = 40'd32768;
    tick();
    wr_en = 1'b0;
    tick();
    busy    = 1'b0;
    rd_en   = 1'b1;
    rd_addr = 8'd0;
    tick();
    rd_en = 1'b0;
    chk("coll_valid", rd_valid, 1'b1);
    chk("coll_old", rd_data, 16'h7FFF);
    m_mem[0] = 16'd1;
    m_count  = 1;
    rd(0, 16'd1, "coll_reread");
    chk("coll_count", count, 9'd1);

    // Random samples against the model
    do_clr();
    for (int i = 0; i < 40; i++) begin
      wr(rand_acc());
      if ($urandom_range(0, 3) == 0) tick();
    end
    tick(); tick(); tick();
    chk("rand_count", count, 9'(m_count));
    chk("rand_sat", sat_flag, m_sat);
    chk("rand_full", full, 1'b0);
    chk("rand_drop", drop_err, 1'b0);
    for (int i = 0; i < m_count; i++) rd(i, m_mem[i], "rand_rd");

    // clr coincident with wr_en
    a = 64'sd7 * 64'sd32768;
    clr    = 1'b1;
    wr_en  = 1'b1;
    acc_in = a[39:0];
    tick();
    clr = 1'b0; wr_en = 1'b0;
    m_count = 0; m_sat = 1'b0;
    tick(); tick(); tick();
    chk("clrwr_count", count, 9'd0);
    chk("clrwr_sat", sat_flag, 1'b0);
    rd(0, m_mem[0], "clrwr_rd0");

    // Reset asserted while a sample is in flight
    a = 64'sd9 * 64'sd32768;
    wr_en  = 1'b1;
    acc_in = a[39:0];
    tick();
    wr_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rstrace");
    tick();
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("rstrace_count_after", count, 9'd0);
    rd(0, m_mem[0], "rstrace_rd0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
